// File: rtl/sprite_rom_pkg.sv
// Shared types and defaults for the sprite ROM arbiter: ROM geometry,
// ownership state encoding and the read-tag record that tracks ROM latency.
package sprite_rom_pkg;

    localparam int ROM_ADDR_WIDTH = 20;
    localparam int ROM_DATA_WIDTH = 12;
    localparam int TAG_IDX_W      = 2;   // covers up to four requesters
    localparam int STAT_W         = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : STAT_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// Combinational circular priority pick: the first requester after ptr wins,
// with ptr itself checked last.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with burst locking in front of a 1-cycle registered ROM.
// Define SPRITE_ROM_ARB_STATS_EN to add grant and conflict statistics outputs.
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int MAX_BURST  = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  lock,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  rvalid,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic [ADDR_WIDTH-1:0]               rom_addr,
`ifdef SPRITE_ROM_ARB_STATS_EN
    output logic [NUM_REQ-1:0][STAT_W-1:0]      stat_grants,
    output logic [STAT_W-1:0]                   stat_conflicts,
`endif
    input  logic [DATA_WIDTH-1:0]               rom_dout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] owner, owner_next;
    logic [IDX_W-1:0] rr_ptr, ptr_next;
    logic [CNT_W-1:0] burst_cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] rom_addr_next;
    rd_tag_t          tag1, tag1_next, tag2;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               lock_hold;
    logic               grant_any;
    logic [IDX_W-1:0]   win;

    rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A locked owner keeps the port until its burst budget is spent.
    assign lock_hold = (state == OWNED) && req[owner] && lock[owner]
                    && (burst_cnt < CNT_W'(MAX_BURST - 1));
    assign win       = lock_hold ? owner : pick_idx;
    assign grant_any = !rst && (lock_hold || pick_any);

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any)
                gnt[i] = lock_hold ? (owner == IDX_W'(i)) : pick_gnt[i];
        end
    end

    always_comb begin
        state_next    = IDLE;
        owner_next    = owner;
        ptr_next      = rr_ptr;
        cnt_next      = burst_cnt;
        rom_addr_next = rom_addr;
        tag1_next     = '{valid: 1'b0, idx: '0};
        if (grant_any) begin
            state_next    = OWNED;
            owner_next    = win;
            ptr_next      = win;
            rom_addr_next = addr[win];
            tag1_next     = '{valid: 1'b1, idx: TAG_IDX_W'(win)};
            if (state == OWNED && owner == win)
                cnt_next = (&burst_cnt) ? burst_cnt : CNT_W'(burst_cnt + 1'b1);
            else
                cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            rom_addr  <= '0;
            tag1      <= '0;
            tag2      <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            rr_ptr    <= ptr_next;
            burst_cnt <= cnt_next;
            rom_addr  <= rom_addr_next;
            tag1      <= tag1_next;
            tag2      <= tag1;
        end
    end

    // Stage 2 lines up with the ROM's registered output.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rvalid[i] = tag2.valid && (tag2.idx == TAG_IDX_W'(i));
    end

    assign rdata = rom_dout;

`ifdef SPRITE_ROM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (gnt[i]) stat_grants[i] <= stat_inc(stat_grants[i]);
            if ($countones(req) >= 2)
                stat_conflicts <= stat_inc(stat_conflicts);
        end
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench: grants checked each cycle, read returns checked
// against a scoreboard filled when each grant is observed.
module tb_sprite_rom_arbiter;

    localparam int NR = 2;
    localparam int AW = 20;
    localparam int DW = 12;
    localparam int MB = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req = '0;
    logic [NR-1:0]       lock = '0;
    logic [NR-1:0][AW-1:0] addr = '0;
    logic [NR-1:0]       gnt;
    logic [NR-1:0]       rvalid;
    logic [DW-1:0]       rdata;
    logic [AW-1:0]       rom_addr;
    logic [DW-1:0]       rom_dout = '0;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic push_en = 1'b1;

    typedef struct {
        logic [NR-1:0] oh;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    sprite_rom_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .addr     (addr),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[11:0] ^ a[19:8] ^ 12'h3C5;
    endfunction

    // Sprite ROM model: registered output, one cycle of latency.
    always @(posedge clk) rom_dout <= rom_word(rom_addr);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_gnt(input string tag, input logic [NR-1:0] exp);
        exp_t e;
        @(negedge clk);
        check(tag, gnt, exp);
        if (exp != '0 && push_en) begin
            e.oh   = exp;
            e.data = rom_word(addr[exp[1]]);
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid != '0) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", rvalid, '0);
            end else begin
                e = sb.pop_front();
                check("rvalid_idx", rvalid, e.oh);
                check("rdata", rdata, e.data);
                check("rvalid_cycle", cyc, e.cyc);
            end
        end
    end

    logic [NR-1:0] burst_seq [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                     2'b01, 2'b01, 2'b01, 2'b01};

    initial begin
        // Reset with requests pending: grants must stay low.
        rst = 1'b1;
        req = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check("gnt_in_rst", gnt, '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt", gnt, '0);
            check("idle_rvalid", rvalid, '0);
            check("idle_rom_addr", rom_addr, '0);
            @(posedge clk);
            #1;
        end

        // Single reads from each requester.
        addr[0] = 20'h00010;
        req = 2'b01;
        expect_gnt("single0_gnt", 2'b01);
        req = '0;
        @(negedge clk);
        check("single0_rom_addr", rom_addr, 20'h00010);
        check("single0_gnt_off", gnt, '0);
        @(posedge clk);
        #1;
        idle(3);
        addr[1] = 20'h00777;
        req = 2'b10;
        expect_gnt("single1_gnt", 2'b10);
        req = '0;
        idle(3);

        // Unlocked contention alternates.
        addr[0] = 20'h00200;
        addr[1] = 20'h30300;
        req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            expect_gnt("rr_gnt", (k % 2 == 0) ? 2'b01 : 2'b10);
            addr[k % 2] = addr[k % 2] + 20'h00011;
        end
        req = '0;
        idle(4);

        // Locked burst with forced rotation after MAX_BURST grants.
        addr[0] = 20'h04000;
        addr[1] = 20'h05000;
        req  = 2'b11;
        lock = 2'b01;
        for (int k = 0; k < 9; k++) begin
            expect_gnt("burst_gnt", burst_seq[k]);
            addr[0] = addr[0] + 20'h1;
        end
        req  = '0;
        lock = '0;
        idle(4);

        // Lock released mid-burst.
        addr[1] = 20'h00ABC;
        req = 2'b10;
        expect_gnt("unlock_seed_gnt", 2'b10);
        req = '0;
        idle(3);
        addr[0] = 20'h00100;
        addr[1] = 20'h00900;
        req  = 2'b11;
        lock = 2'b01;
        expect_gnt("unlock_gnt0", 2'b01);
        expect_gnt("unlock_gnt1", 2'b01);
        lock = 2'b00;
        expect_gnt("unlock_gnt2", 2'b10);
        expect_gnt("unlock_gnt3", 2'b01);
        req = '0;
        idle(4);

        // Reset one cycle after a grant: that read must never return.
        addr[0] = 20'h00055;
        req = 2'b01;
        push_en = 1'b0;
        expect_gnt("prerst_gnt", 2'b01);
        push_en = 1'b1;
        rst = 1'b1;
        req = '0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_gnt", gnt, '0);
            check("midrst_rvalid", rvalid, '0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_rvalid", rvalid, '0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("postrst_rom_addr", rom_addr, '0);
        @(posedge clk);
        #1;
        addr[0] = 20'h00123;
        addr[1] = 20'h00456;
        req = 2'b11;
        expect_gnt("postrst_first_gnt", 2'b01);
        expect_gnt("postrst_second_gnt", 2'b10);
        req = '0;
        idle(5);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
